// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, controller states and the
// supported operand width range.
package alu_pkg;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [2:0] {
        OP_ZERO = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_MUL  = 3'd6,
        OP_DIV  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Controller-to-ALU request/response bundle; the controller is the master.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             gt;
    logic             eq;
    logic             ne;
    logic             dz;

    modport master (
        output start, op, a, b,
        input  ready, done, result, gt, eq, ne, dz
    );

    modport slave (
        input  start, op, a, b,
        output ready, done, result, gt, eq, ne, dz
    );
endinterface

// File: rtl/seq_alu_muldiv_iter.sv
// Shared iterative datapath: shift-add multiply (LSB first) and restoring
// divide (MSB first), one bit per step, over a single 2*WIDTH accumulator.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             mode,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Upper half is the partial product (mul) or partial remainder (div);
    // lower half holds the multiplier / dividend being shifted out.
    logic [WIDTH-1:0] hi;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    assign hi       = acc_q[2*WIDTH-1:WIDTH];
    assign mul_sum  = {1'b0, hi} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign div_sh   = {hi, acc_q[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, opnd_q});
    assign div_diff = div_sh - {1'b0, opnd_q};

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        if (load) begin
            acc_d  = {{WIDTH{1'b0}}, a};
            opnd_d = b;
            cnt_d  = CNT_W'(WIDTH);
        end else if (step && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (mode) begin
                acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], div_ge};
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last   = (cnt_q == CNT_W'(1));
    assign result = acc_q[WIDTH-1:0];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: accepts one op in IDLE, runs single-cycle or iterative
// mul/div, then publishes result and compare flags with a one-cycle done.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("seq_alu: WIDTH out of supported range");
    end

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             ne_q, ne_d;
    logic             dz_q, dz_d;

    logic             accept;
    logic             iter_load;
    logic             iter_last;
    logic [WIDTH-1:0] iter_result;
    logic [WIDTH-1:0] alu_res;

    assign accept    = bus.start && ready_q && (state_q == IDLE);
    assign iter_load = accept && ((op_e'(bus.op) == OP_MUL) ||
                                  ((op_e'(bus.op) == OP_DIV) && (bus.b != '0)));

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (iter_load),
        .mode   (state_q == DIV),
        .step   ((state_q == MUL) || (state_q == DIV)),
        .a      (bus.a),
        .b      (bus.b),
        .last   (iter_last),
        .result (iter_result)
    );

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ZERO: alu_res = '0;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_MUL:  alu_res = iter_result;
            OP_DIV:  alu_res = (b_q == '0) ? '1 : iter_result;
            default: alu_res = '0;
        endcase
    end

    // Outputs are only ever written on the edge that closes DONE, which is
    // also the edge that raises done, so they never change mid-operation.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        gt_d     = gt_q;
        eq_d     = eq_q;
        ne_d     = ne_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d  = bus.a;
                    b_d  = bus.b;
                    op_d = op_e'(bus.op);
                    case (op_e'(bus.op))
                        OP_MUL:  state_d = MUL;
                        OP_DIV:  state_d = (bus.b == '0) ? DONE : DIV;
                        default: state_d = DONE;
                    endcase
                end
            end
            MUL, DIV: begin
                if (iter_last) state_d = DONE;
            end
            DONE: begin
                state_d  = IDLE;
                result_d = alu_res;
                gt_d     = (a_q > b_q);
                eq_d     = (a_q == b_q);
                ne_d     = (a_q != b_q);
                dz_d     = (op_q == OP_DIV) && (b_q == '0);
            end
            default: state_d = IDLE;
        endcase
        done_d  = (state_q == DONE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ZERO;
            a_q      <= '0;
            b_q      <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            ne_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            result_q <= result_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            ne_q     <= ne_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.gt     = gt_q;
    assign bus.eq     = eq_q;
    assign bus.ne     = ne_q;
    assign bus.dz     = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a 32-bit and an 8-bit instance on a shared
// clock and reset, each scenario checking its own hand-computed vectors.
module tb_seq_alu;

    logic clk = 1'b0;
    logic rst_n;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   lat;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) if32 ();
    seq_alu_if #(.WIDTH(8))  if8 ();

    seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

    // Drive a request in the low phase so it is accepted on the next rising edge.
    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if32.start = 1'b1; if32.op = op; if32.a = a; if32.b = b;
        @(posedge clk);
        #1 if32.start = 1'b0;
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        if8.start = 1'b1; if8.op = op; if8.a = a; if8.b = b;
        @(posedge clk);
        #1 if8.start = 1'b0;
    endtask

    // Latency is counted in cycles after the accept edge; -1 means no done seen.
    task automatic wait_done32(output int n_done);
        n_done = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (if32.done) begin n_done = n; break; end
        end
    endtask

    task automatic wait_done8(output int n_done);
        n_done = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (if8.done) begin n_done = n; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++; if (if32.ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b expected 1", if32.ready); end
        vec_cnt++; if (if32.done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b expected 0", if32.done); end
        vec_cnt++; if (if32.result !== 32'h0) begin err_cnt++; $display("FAIL reset_result: got %h expected 0", if32.result); end
        vec_cnt++; if ({if32.gt, if32.eq, if32.ne, if32.dz} !== 4'b0000) begin err_cnt++; $display("FAIL reset_flags: got %b expected 0000", {if32.gt, if32.eq, if32.ne, if32.dz}); end
        vec_cnt++; if ({if8.ready, if8.done, if8.dz} !== 3'b100) begin err_cnt++; $display("FAIL reset_w8: got %b expected 100", {if8.ready, if8.done, if8.dz}); end
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        issue32(3'd4, 32'hFFFF_FFFF, 32'h1);
        vec_cnt++; if (if32.ready !== 1'b0) begin err_cnt++; $display("FAIL add_busy_ready: got %b expected 0", if32.ready); end
        wait_done32(lat);
        vec_cnt++; if (lat !== 1) begin err_cnt++; $display("FAIL add_latency: got %0d expected 1", lat); end
        vec_cnt++; if (if32.result !== 32'h0) begin err_cnt++; $display("FAIL add_wrap_result: got %h expected 00000000", if32.result); end
        vec_cnt++; if ({if32.gt, if32.eq, if32.ne} !== 3'b101) begin err_cnt++; $display("FAIL add_flags: got %b expected 101", {if32.gt, if32.eq, if32.ne}); end
        vec_cnt++; if (if32.ready !== 1'b1) begin err_cnt++; $display("FAIL add_done_ready: got %b expected 1", if32.ready); end
        issue32(3'd5, 32'h0, 32'h1);
        wait_done32(lat);
        vec_cnt++; if (lat !== 1) begin err_cnt++; $display("FAIL sub_latency: got %0d expected 1", lat); end
        vec_cnt++; if (if32.result !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL sub_wrap_result: got %h expected ffffffff", if32.result); end
        vec_cnt++; if ({if32.gt, if32.eq, if32.ne} !== 3'b001) begin err_cnt++; $display("FAIL sub_flags: got %b expected 001", {if32.gt, if32.eq, if32.ne}); end
    endtask

    task automatic test_mul();
        issue32(3'd6, 32'h0001_0000, 32'h0001_0001);
        if32.a = 32'h0; if32.b = 32'h0; if32.op = 3'd4;
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (if32.done) begin lat = n; break; end
            if (n == 10) begin
                vec_cnt++; if (if32.ready !== 1'b0) begin err_cnt++; $display("FAIL mul_busy_ready: got %b expected 0", if32.ready); end
            end
            // Stray requests while busy must be dropped, not queued.
            if32.start = (n == 5) || (n == 20);
        end
        if32.start = 1'b0;
        vec_cnt++; if (lat !== 33) begin err_cnt++; $display("FAIL mul_latency: got %0d expected 33", lat); end
        vec_cnt++; if (if32.result !== 32'h0001_0000) begin err_cnt++; $display("FAIL mul_result: got %h expected 00010000", if32.result); end
        vec_cnt++; if ({if32.gt, if32.eq, if32.ne} !== 3'b001) begin err_cnt++; $display("FAIL mul_flags: got %b expected 001", {if32.gt, if32.eq, if32.ne}); end
        repeat (3) @(negedge clk);
        vec_cnt++; if ({if32.done, if32.ready} !== 2'b01) begin err_cnt++; $display("FAIL mul_no_queued_op: got done,ready=%b expected 01", {if32.done, if32.ready}); end
        vec_cnt++; if (if32.result !== 32'h0001_0000) begin err_cnt++; $display("FAIL mul_result_held: got %h expected 00010000", if32.result); end
    endtask

    task automatic test_div();
        issue8(3'd7, 8'd200, 8'd7);
        wait_done8(lat);
        vec_cnt++; if (lat !== 9) begin err_cnt++; $display("FAIL div_latency: got %0d expected 9", lat); end
        vec_cnt++; if (if8.result !== 8'd28) begin err_cnt++; $display("FAIL div_quotient: got %0d expected 28", if8.result); end
        vec_cnt++; if ({if8.gt, if8.dz} !== 2'b10) begin err_cnt++; $display("FAIL div_gt_dz: got %b expected 10", {if8.gt, if8.dz}); end
        issue8(3'd7, 8'd200, 8'd0);
        wait_done8(lat);
        vec_cnt++; if (lat !== 1) begin err_cnt++; $display("FAIL divz_latency: got %0d expected 1", lat); end
        vec_cnt++; if (if8.result !== 8'hFF) begin err_cnt++; $display("FAIL divz_result: got %h expected ff", if8.result); end
        vec_cnt++; if (if8.dz !== 1'b1) begin err_cnt++; $display("FAIL divz_dz: got %b expected 1", if8.dz); end
        issue8(3'd1, 8'hF0, 8'h3C);
        wait_done8(lat);
        vec_cnt++; if (if8.result !== 8'h30) begin err_cnt++; $display("FAIL and8_result: got %h expected 30", if8.result); end
        vec_cnt++; if (if8.dz !== 1'b0) begin err_cnt++; $display("FAIL dz_cleared: got %b expected 0", if8.dz); end
        issue8(3'd0, 8'h55, 8'h55);
        wait_done8(lat);
        vec_cnt++; if ({if8.result, if8.eq, if8.ne} !== {8'h00, 2'b10}) begin err_cnt++; $display("FAIL zero_op: got result=%h eq,ne=%b expected 00 10", if8.result, {if8.eq, if8.ne}); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        if32.start = 1'b1; if32.op = 3'd1; if32.a = 32'hF0F0; if32.b = 32'hFF00;
        @(negedge clk);
        vec_cnt++; if (if32.ready !== 1'b0) begin err_cnt++; $display("FAIL b2b_busy: got %b expected 0", if32.ready); end
        if32.op = 3'd2;
        @(negedge clk);
        vec_cnt++; if ({if32.done, if32.result} !== {1'b1, 32'h0000_F000}) begin err_cnt++; $display("FAIL b2b_and: got done=%b result=%h expected 1 0000f000", if32.done, if32.result); end
        @(negedge clk);
        if32.op = 3'd3;
        @(negedge clk);
        vec_cnt++; if ({if32.done, if32.result} !== {1'b1, 32'h0000_FFF0}) begin err_cnt++; $display("FAIL b2b_or: got done=%b result=%h expected 1 0000fff0", if32.done, if32.result); end
        @(negedge clk);
        if32.op = 3'd4; if32.a = 32'd5; if32.b = 32'd5;
        @(negedge clk);
        vec_cnt++; if ({if32.done, if32.result} !== {1'b1, 32'h0000_0FF0}) begin err_cnt++; $display("FAIL b2b_xor: got done=%b result=%h expected 1 00000ff0", if32.done, if32.result); end
        vec_cnt++; if ({if32.gt, if32.eq, if32.ne} !== 3'b001) begin err_cnt++; $display("FAIL b2b_xor_flags: got %b expected 001", {if32.gt, if32.eq, if32.ne}); end
        @(negedge clk);
        if32.start = 1'b0;
        @(negedge clk);
        vec_cnt++; if ({if32.done, if32.result} !== {1'b1, 32'd10}) begin err_cnt++; $display("FAIL eq_add: got done=%b result=%h expected 1 0000000a", if32.done, if32.result); end
        vec_cnt++; if ({if32.gt, if32.eq, if32.ne} !== 3'b010) begin err_cnt++; $display("FAIL eq_flags: got %b expected 010", {if32.gt, if32.eq, if32.ne}); end
    endtask

    task automatic test_reset_mid_op();
        issue32(3'd6, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++; if ({if32.ready, if32.done} !== 2'b10) begin err_cnt++; $display("FAIL abort_ready_done: got %b expected 10", {if32.ready, if32.done}); end
        vec_cnt++; if (if32.result !== 32'h0) begin err_cnt++; $display("FAIL abort_result: got %h expected 0", if32.result); end
        vec_cnt++; if ({if32.gt, if32.eq, if32.ne, if32.dz} !== 4'b0000) begin err_cnt++; $display("FAIL abort_flags: got %b expected 0000", {if32.gt, if32.eq, if32.ne, if32.dz}); end
        @(negedge clk);
        rst_n = 1'b1;
        issue32(3'd4, 32'd3, 32'd4);
        wait_done32(lat);
        vec_cnt++; if (lat !== 1) begin err_cnt++; $display("FAIL post_abort_latency: got %0d expected 1", lat); end
        vec_cnt++; if (if32.result !== 32'd7) begin err_cnt++; $display("FAIL post_abort_result: got %h expected 00000007", if32.result); end
    endtask

    initial begin
        rst_n = 1'b0;
        if32.start = 1'b0; if32.op = 3'd0; if32.a = '0; if32.b = '0;
        if8.start  = 1'b0; if8.op  = 3'd0; if8.a  = '0; if8.b  = '0;
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
